// File: rtl/sparkle_pkg.sv
// Shared sizes, scan-state encoding and a row-extraction helper for the sparkle matrix.
// The optional PWM dimming mode is selected with the SPARKLE_PWM_EN macro.
package sparkle_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 8;
  localparam int NPIX   = 32;
  localparam int LIFE_W = 4;
  localparam int ROW_W  = 2;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  typedef logic [LIFE_W-1:0] life_t;

  // Byte of the frame belonging to one matrix row (pixel i lives in row i/8).
  function automatic logic [COLS-1:0] row_bits(input logic [NPIX-1:0] f,
                                                input logic [ROW_W-1:0] r);
    return f[{r, 3'b000} +: COLS];
  endfunction

endpackage

// File: rtl/matrix_scan.sv
// Row-multiplexed scan of the 4x8 matrix: BLANK/SHOW slot FSM, row counter, and,
// when SPARKLE_PWM_EN is defined, a free-running 4-bit PWM that dims columns by life.
module matrix_scan
  import sparkle_pkg::*;
#(
  parameter int SCAN_DIV  = 3_000,
  parameter int BLANK_CYC = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef SPARKLE_PWM_EN
  input  logic [NPIX*LIFE_W-1:0]   life_i,
`else
  input  logic [NPIX-1:0]          frame_i,
`endif
  output logic [ROWS-1:0]          row_n_o,
  output logic [COLS-1:0]          col_n_o
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYC - 1);

  scan_state_e       state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ROWS-1:0]   row_n_q, row_n_d;
  logic [COLS-1:0]   col_n_q, col_n_d;

  // Outputs are registered from next-state values so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
      slot_q  <= '0;
      row_q   <= '0;
      row_n_q <= '1;
      col_n_q <= '1;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      row_q   <= row_d;
      row_n_q <= row_n_d;
      col_n_q <= col_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK: begin
        if (slot_q == BLANK_LAST) state_d = SHOW;
        else                      state_d = BLANK;
      end
      SHOW: begin
        if (slot_q == SLOT_LAST) state_d = BLANK;
        else                     state_d = SHOW;
      end
      default: state_d = BLANK;
    endcase
    if (slot_q == SLOT_LAST) slot_d = '0;
    else                     slot_d = slot_q + 1'b1;
    if ((state_q == SHOW) && (state_d == BLANK)) row_d = row_q + 1'b1;
    else                                         row_d = row_q;
  end

`ifdef SPARKLE_PWM_EN
  logic [LIFE_W-1:0] pwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= '0;
    else        pwm_q <= pwm_q + 1'b1;
  end
`endif

  always_comb begin
    row_n_d = '1;
    col_n_d = '1;
    if (state_d == SHOW) begin
      row_n_d = ~({{(ROWS-1){1'b0}}, 1'b1} << row_d);
`ifdef SPARKLE_PWM_EN
      // A column is lit only while the PWM phase is below that pixel's remaining life.
      for (int c = 0; c < COLS; c++) begin
        col_n_d[c] = ~(pwm_q < life_i[(int'(row_d) * COLS + c) * LIFE_W +: LIFE_W]);
      end
`else
      col_n_d = ~row_bits(frame_i, row_d);
`endif
    end else begin
      row_n_d = '1;
      col_n_d = '1;
    end
  end

  assign row_n_o = row_n_q;
  assign col_n_o = col_n_q;

endmodule

// File: rtl/sparkle_matrix.sv
// Random sparkle effect for a 4x8 LED matrix: spark/decay prescalers and per-pixel life
// counters feeding matrix_scan. Define SPARKLE_PWM_EN for life-proportional dimming.
module sparkle_matrix
  import sparkle_pkg::*;
#(
  parameter int SPARK_DIV = 1_200_000,
  parameter int DECAY_DIV = 600_000,
  parameter int SCAN_DIV  = 3_000,
  parameter int BLANK_CYC = 16,
  parameter int LIFE      = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         rnd,
  output logic [NPIX-1:0]     frame,
  output logic [ROWS-1:0]     row_n,
  output logic [COLS-1:0]     col_n
);

  localparam int SP_W = $clog2(SPARK_DIV);
  localparam int DC_W = $clog2(DECAY_DIV);
  localparam logic [SP_W-1:0] SPARK_LAST = SP_W'(SPARK_DIV - 1);
  localparam logic [DC_W-1:0] DECAY_LAST = DC_W'(DECAY_DIV - 1);
  localparam life_t           LIFE_INIT  = LIFE_W'(LIFE);

  logic [SP_W-1:0]              spark_cnt_q, spark_cnt_d;
  logic [DC_W-1:0]              decay_cnt_q, decay_cnt_d;
  logic [NPIX-1:0][LIFE_W-1:0]  life_q, life_d;
  logic [NPIX-1:0]              frame_q, frame_d;
  logic                         spark_evt_s, decay_evt_s, spark_hit_s;
  logic                         unused_rnd;

  assign unused_rnd = ^rnd[31:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spark_cnt_q <= '0;
      decay_cnt_q <= '0;
      life_q      <= '0;
      frame_q     <= '0;
    end else begin
      spark_cnt_q <= spark_cnt_d;
      decay_cnt_q <= decay_cnt_d;
      life_q      <= life_d;
      frame_q     <= frame_d;
    end
  end

  always_comb begin
    spark_evt_s = (spark_cnt_q == SPARK_LAST);
    decay_evt_s = (decay_cnt_q == DECAY_LAST);
    if (spark_evt_s) spark_cnt_d = '0;
    else             spark_cnt_d = spark_cnt_q + 1'b1;
    if (decay_evt_s) decay_cnt_d = '0;
    else             decay_cnt_d = decay_cnt_q + 1'b1;
    // rnd is only looked at on the spark cycle; a zero brightness field means "no spark".
    spark_hit_s = spark_evt_s && (rnd[7:5] != 3'b000);
    for (int i = 0; i < NPIX; i++) begin
      if (spark_hit_s && (rnd[4:0] == 5'(i)))    life_d[i] = LIFE_INIT;
      else if (decay_evt_s && (life_q[i] != '0)) life_d[i] = life_q[i] - 1'b1;
      else                                       life_d[i] = life_q[i];
      frame_d[i] = (life_q[i] != '0);
    end
  end

  matrix_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef SPARKLE_PWM_EN
    .life_i  (life_q),
`else
    .frame_i (frame_q),
`endif
    .row_n_o (row_n),
    .col_n_o (col_n)
  );

  assign frame = frame_q;

endmodule

// File: tb/tb_sparkle_matrix.sv
// Directed self-checking bench for sparkle_matrix; a second instance with a fast spark
// and slow decay fills the matrix so the row scan can be checked across a full refresh.
module tb_sparkle_matrix;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic [31:0] rnd, rnd2;
  logic [31:0] frame, frame2;
  logic [3:0]  row_n, row2_n;
  logic [7:0]  col_n, col2_n;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          k;
  int          slot, row;
  logic [31:0] frame_exp;
  logic [7:0]  byte_v, exp_col;
  logic [3:0]  exp_row;
  logic [4:0]  pix[12];

  always #5 clk = ~clk;

  sparkle_matrix #(
    .SPARK_DIV(8), .DECAY_DIV(4), .SCAN_DIV(10), .BLANK_CYC(2), .LIFE(3)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .rnd(rnd), .frame(frame), .row_n(row_n), .col_n(col_n)
  );

  sparkle_matrix #(
    .SPARK_DIV(2), .DECAY_DIV(4000), .SCAN_DIV(10), .BLANK_CYC(2), .LIFE(2)
  ) u_dut_fill (
    .clk(clk), .rst_n(rst2_n), .rnd(rnd2), .frame(frame2), .row_n(row2_n), .col_n(col2_n)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, then release between edges so the next edge is edge 1.
  task automatic reset_main();
    rst_n = 1'b0;
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    rnd    = 32'h0000_0025;
    rnd2   = 32'h0000_0000;
    step(2);
    check_val("rst_frame", frame, 32'h0000_0000);
    check_val("rst_row_n", {28'h0, row_n}, 32'h0000_000F);
    check_val("rst_col_n", {24'h0, col_n}, 32'h0000_00FF);

    // First spark lights pixel 5, then three decays clear it.
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check_val("blank_after_rst", {28'h0, row_n}, 32'h0000_000F);
    step(1);
    check_val("first_show", {28'h0, row_n}, 32'h0000_000E);
    step(6);
    check_val("pre_spark", frame, 32'h0000_0000);
    step(1);
    check_val("spark_lit", frame, 32'h0000_0020);
    rnd = 32'h0000_0005;
    step(10);
    check_val("life1_lit", frame, 32'h0000_0020);
    step(1);
    check_val("life0_lag", frame, 32'h0000_0020);
    step(1);
    check_val("decayed", frame, 32'h0000_0000);

    // Zero brightness field never sparks.
    rnd = 32'h0000_0005;
    reset_main();
    for (int i = 0; i < 5; i++) begin
      step(20);
      check_val("no_spark", frame, 32'h0000_0000);
    end

    // Spark on pixel 5 coincides with a decay; pixel 6 decays on the same edge.
    rnd = 32'h0000_0026;
    reset_main();
    step(8);
    rnd = 32'h0000_0025;
    step(8);
    rnd = 32'h0000_0005;
    step(1);
    check_val("coincide", frame, 32'h0000_0060);
    step(3);
    check_val("px6_lag", frame, 32'h0000_0060);
    step(1);
    check_val("px6_gone", frame, 32'h0000_0020);
    step(7);
    check_val("px5_reloaded", frame, 32'h0000_0020);
    step(1);
    check_val("px5_gone", frame, 32'h0000_0000);

    // Asynchronous reset in the middle of a row-0 SHOW slot.
    rnd = 32'h0000_0025;
    reset_main();
    step(45);
    check_val("mid_show_row", {28'h0, row_n}, 32'h0000_000E);
`ifndef SPARKLE_PWM_EN
    check_val("mid_show_col", {24'h0, col_n}, 32'h0000_00DF);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_frame", frame, 32'h0000_0000);
    check_val("async_row_n", {28'h0, row_n}, 32'h0000_000F);
    check_val("async_col_n", {24'h0, col_n}, 32'h0000_00FF);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill frame 0xFF0000A5 on the second instance, then check a full refresh.
    pix = '{5'd0, 5'd2, 5'd5, 5'd7, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31};
    @(negedge clk);
    rst2_n = 1'b1;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      rnd2 = {24'h0, 3'b001, pix[i]};
      step(2);
      k += 2;
    end
    rnd2 = 32'h0000_0000;
    step(1);
    k += 1;
    frame_exp = 32'hFF00_00A5;
    check_val("fill_frame", frame2, frame_exp);
    step(5);
    k += 5;
    for (int i = 0; i < 40; i++) begin
      slot    = k % 10;
      row     = (k / 10) % 4;
      byte_v  = frame_exp[row*8 +: 8];
      exp_row = 4'hF;
      exp_col = 8'hFF;
      if (slot >= 2) begin
        exp_row = ~(4'b0001 << row);
`ifdef SPARKLE_PWM_EN
        if (((k - 1) % 16) < 2) exp_col = ~byte_v;
`else
        exp_col = ~byte_v;
`endif
      end
      check_val($sformatf("scan_row_n_k%0d", k), {28'h0, row2_n}, {28'h0, exp_row});
      check_val($sformatf("scan_col_n_k%0d", k), {24'h0, col2_n}, {24'h0, exp_col});
      step(1);
      k += 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sparkle_matrix.md
SPARKLE_MATRIX -- requirements
Module: sparkle_matrix

Interface
REQ-001 Parameter SPARK_DIV, default 1_200_000, clk cycles between spark events (>=2).
REQ-002 Parameter DECAY_DIV, default 600_000, clk cycles between decay events (>=2).
REQ-003 Parameter SCAN_DIV, default 3_000, clk cycles per row slot, blanking included (> BLANK_CYC+1).
REQ-004 Parameter BLANK_CYC, default 16, dead cycles at the start of each row slot (>=1).
REQ-005 Parameter LIFE, default 12, decay events a freshly lit pixel stays on (1..15).
REQ-006 Port clk  in  1  system clock; one clock, reset is asynchronous and active-low.
REQ-007 Port rst_n  in  1  asynchronous active-low reset.
REQ-008 Port rnd  in  32  free-running random word from the upstream generator, sampled only on spark events.
REQ-009 Port frame  out  32  bit i = pixel i lit; pixel i = row i/8, column i%8.
REQ-010 Port row_n  out  4  active-low row select, at most one bit low.
REQ-011 Port col_n  out  8  active-low column drive for the selected row.

Function
REQ-012 Spark counter counts 0..SPARK_DIV-1 and wraps; a spark event occurs on the cycle it equals SPARK_DIV-1.
REQ-013 On a spark event, idx = rnd[4:0]; if rnd[7:5] != 0, life[idx] loads LIFE on the next edge; otherwise nothing changes.
REQ-014 Decay counter counts 0..DECAY_DIV-1 and wraps; on a decay event every nonzero life[i] decrements by 1, and zero stays zero (no underflow).
REQ-015 Spark and decay on the same cycle: the sparked pixel loads LIFE (spark wins), and all other pixels decay.
REQ-016 frame[i] = (life[i] != 0), registered, one cycle after the life update.
REQ-017 Scan FSM states are BLANK and SHOW: BLANK lasts BLANK_CYC cycles with row_n=4'hF and col_n=8'hFF; SHOW lasts SCAN_DIV-BLANK_CYC cycles with row_n bit r low and col_n = ~frame[8r+7:8r]; SHOW->BLANK advances r.
REQ-018 Row index r wraps from 3 to 0; a full refresh is 4*SCAN_DIV cycles.
REQ-019 col_n reflects frame changes during SHOW within one cycle; row_n changes only on state transitions.
REQ-020 The rnd value is never held or handshaken; its value outside spark cycles has no effect.

Reset
REQ-021 On rst_n low: all life counters = 0, frame = 0, all prescalers = 0, r = 0, state = BLANK, row_n = 4'hF, col_n = 8'hFF.
REQ-022 Reset asserted mid-slot or mid-decay takes effect immediately; after release the first spark comes SPARK_DIV cycles later and the first SHOW comes BLANK_CYC cycles later.

Configuration
REQ-023 Macro SPARKLE_PWM_EN defined: in SHOW, column c of row r is driven low only while a 4-bit PWM counter (free-running, +1 per clk) is < life[8r+c], so brightness is proportional to remaining life.
REQ-024 Macro SPARKLE_PWM_EN undefined: columns are on/off per frame (REQ-017), there is no PWM counter, and ports are unchanged.

Structure
REQ-025 Package sparkle_pkg holds ROWS=4, COLS=8, NPIX=32, LIFE_W=4 and the scan-state enum {BLANK, SHOW}.
REQ-026 Sub-module matrix_scan holds the scan FSM, row counter and (optionally) PWM; sparkle_matrix holds the prescalers and life array.

Verification (bench params: SPARK_DIV=8, DECAY_DIV=4, SCAN_DIV=10, BLANK_CYC=2, LIFE=3)
REQ-027 rnd=32'h0000_0025 held, first spark -> frame=32'h0000_0020 one cycle later; the pixel clears after 3 decay events.
REQ-028 rnd=32'h0000_0005 (rnd[7:5]=0) -> frame stays 0 for 100 cycles.
REQ-029 Spark and decay coincide on lit pixel 5 with life=1 -> life[5]=3, frame[5] stays 1.
REQ-030 frame=32'hFF00_00A5 forced via sparks -> row 0 SHOW shows col_n=8'h5A, rows 1-2 col_n=8'hFF, row 3 col_n=8'h00; each slot starts with 2 blank cycles and r wraps 3->0.
REQ-031 rst_n pulsed low mid-SHOW with pixels lit -> row_n=4'hF, col_n=8'hFF and frame=0 in the same cycle, asynchronously.
REQ-032 With SPARKLE_PWM_EN, life=2 -> the column is low for 2 of every 16 SHOW cycles.
